// File: rtl/reg_writeback.sv
// Writeback stage for the register file: arbitrates ALU and load results onto the
// single write port and keeps a per-register pending-write scoreboard for decode.
module reg_writeback #(
   parameter int DW   = 19,
   parameter int AW   = 3,
   parameter int NREG = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [AW-1:0]   alu_rd,
   input  logic [DW-1:0]   alu_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [AW-1:0]   ld_rd,
   input  logic [DW-1:0]   ld_data,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic [NREG-1:0] busy,
   output logic            sb_err,
   output logic            rf_we,
   output logic [AW-1:0]   rf_wa,
   output logic [DW-1:0]   rf_wd
);

   typedef enum logic [0:0] {
      PRI_LD  = 1'b0,
      PRI_ALU = 1'b1
   } pri_t;

   pri_t            pri_r;
   logic            both_s;
   logic            ld_fire_s;
   logic            alu_fire_s;
   logic [NREG-1:0] inc_s;
   logic [NREG-1:0] dec_s;
   logic [NREG-1:0] busy_nxt_s;
   logic            err_nxt_s;
   logic [1:0]      cnt_r     [NREG];
   logic [1:0]      cnt_nxt_s [NREG];

   // Readies only drop for the source that loses a contended cycle.
   assign both_s     = ld_valid & alu_valid;
   assign ld_ready   = ~both_s | (pri_r == PRI_LD);
   assign alu_ready  = ~both_s | (pri_r == PRI_ALU);
   assign ld_fire_s  = ld_valid & ld_ready;
   assign alu_fire_s = alu_valid & alu_ready;

   // Priority FSM and the registered regfile write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pri_r <= PRI_LD;
         rf_we <= 1'b0;
         rf_wa <= {AW{1'b0}};
         rf_wd <= {DW{1'b0}};
      end else begin
         rf_we <= ld_fire_s | alu_fire_s;
         if (ld_fire_s) begin
            rf_wa <= ld_rd;
            rf_wd <= ld_data;
         end else if (alu_fire_s) begin
            rf_wa <= alu_rd;
            rf_wd <= alu_data;
         end
         if (both_s) begin
            case (pri_r)
               PRI_LD:  pri_r <= PRI_ALU;
               PRI_ALU: pri_r <= PRI_LD;
               default: pri_r <= PRI_LD;
            endcase
         end
      end
   end

   // Per-register issue/retire strobes.
   always_comb begin
      inc_s = {NREG{1'b0}};
      dec_s = {NREG{1'b0}};
      for (int r = 0; r < NREG; r++) begin
         inc_s[r] = iss_valid & (iss_rd == AW'(r));
         dec_s[r] = rf_we & (rf_wa == AW'(r));
      end
   end

   // Next pending counts; saturating at both ends and flagging the error.
   always_comb begin
      err_nxt_s  = sb_err;
      busy_nxt_s = {NREG{1'b0}};
      for (int r = 0; r < NREG; r++) begin
         cnt_nxt_s[r] = cnt_r[r];
         if (inc_s[r] && !dec_s[r]) begin
            if (cnt_r[r] == 2'd3) begin
               err_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s[r] = cnt_r[r] + 2'd1;
            end
         end else if (dec_s[r] && !inc_s[r]) begin
            if (cnt_r[r] == 2'd0) begin
               err_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s[r] = cnt_r[r] - 2'd1;
            end
         end else begin
            cnt_nxt_s[r] = cnt_r[r];
         end
         busy_nxt_s[r] = (cnt_nxt_s[r] != 2'd0);
      end
   end

   // Scoreboard state; busy is registered alongside the counts it mirrors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_r[r] <= 2'd0;
         end
         busy   <= {NREG{1'b0}};
         sb_err <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            cnt_r[r] <= cnt_nxt_s[r];
         end
         busy   <= busy_nxt_s;
         sb_err <= err_nxt_s;
      end
   end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: a behavioural model checked every cycle plus
// hand-computed literal expectations for each scenario.
module tb_reg_writeback;
   localparam int DW = 19;
   localparam int AW = 3;
   localparam int NREG = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_valid, alu_ready, ld_valid, ld_ready, iss_valid;
   logic [AW-1:0]   alu_rd, ld_rd, iss_rd;
   logic [DW-1:0]   alu_data, ld_data;
   logic [NREG-1:0] busy;
   logic            sb_err, rf_we;
   logic [AW-1:0]   rf_wa;
   logic [DW-1:0]   rf_wd;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   reg_writeback #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .busy(busy), .sb_err(sb_err),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: pending counts as plain integers, priority as a bit.
   bit              m_ptr_ld;
   bit              m_we;
   logic [AW-1:0]   m_wa;
   logic [DW-1:0]   m_wd;
   bit              m_err;
   int              m_cnt [NREG];

   function automatic bit ld_wins();
      return ld_valid && (!alu_valid || m_ptr_ld);
   endfunction

   function automatic int delta(input int r);
      return int'(iss_valid && iss_rd == AW'(r)) - int'(m_we && m_wa == AW'(r));
   endfunction

   function automatic int clamp(input int v);
      return (v > 3) ? 3 : ((v < 0) ? 0 : v);
   endfunction

   function automatic bit sb_fault();
      bit f = 1'b0;
      for (int r = 0; r < NREG; r++)
         if (m_cnt[r] + delta(r) > 3 || m_cnt[r] + delta(r) < 0) f = 1'b1;
      return f;
   endfunction

   function automatic logic [NREG-1:0] m_busy();
      logic [NREG-1:0] b = '0;
      for (int r = 0; r < NREG; r++) b[r] = (m_cnt[r] != 0);
      return b;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ptr_ld <= 1'b1;
         m_we     <= 1'b0;
         m_wa     <= '0;
         m_wd     <= '0;
         m_err    <= 1'b0;
         for (int r = 0; r < NREG; r++) m_cnt[r] <= 0;
      end else begin
         if (ld_valid && alu_valid) m_ptr_ld <= !m_ptr_ld;
         for (int r = 0; r < NREG; r++) m_cnt[r] <= clamp(m_cnt[r] + delta(r));
         m_err <= m_err || sb_fault();
         m_we  <= ld_valid || alu_valid;
         if (ld_wins()) begin
            m_wa <= ld_rd;
            m_wd <= ld_data;
         end else if (alu_valid) begin
            m_wa <= alu_rd;
            m_wd <= alu_data;
         end
      end
   end

   // Compare process: registered outputs at negedge, readies once inputs settle.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rf_we", rf_we, m_we);
         if (m_we || rst) begin
            chk("rf_wa", rf_wa, m_wa);
            chk("rf_wd", rf_wd, m_wd);
         end
         chk("busy", busy, m_busy());
         chk("sb_err", sb_err, m_err);
         #2;
         chk("ld_ready", ld_ready, !(ld_valid && alu_valid) || m_ptr_ld);
         chk("alu_ready", alu_ready, !(ld_valid && alu_valid) || !m_ptr_ld);
      end
   end

   task automatic cyc(input bit av, input int ard, input int ad,
                      input bit lv, input int lrd, input int ldd,
                      input bit iv, input int ird);
      @(negedge clk);
      alu_valid = av;  alu_rd = AW'(ard); alu_data = DW'(ad);
      ld_valid  = lv;  ld_rd  = AW'(lrd); ld_data  = DW'(ldd);
      iss_valid = iv;  iss_rd = AW'(ird);
   endtask

   task automatic idle();
      cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0);
   endtask

   task automatic do_reset();
      idle();
      #3 rst = 1'b1;
      #1;
      chk("rst_we", rf_we, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_err", sb_err, 32'd0);
      @(negedge clk);
      #3 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
      iss_valid = 1'b0; iss_rd = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("reset_we", rf_we, 32'd0);
      chk("reset_wa", rf_wa, 32'd0);
      chk("reset_wd", rf_wd, 32'd0);
      chk("reset_busy", busy, 32'd0);
      chk("reset_err", sb_err, 32'd0);

      // Single ALU result, with a matching issue so the scoreboard stays clean.
      cyc(1'b1, 5, 'h1ABCD, 1'b0, 0, 0, 1'b1, 5);
      #1 chk("t1_alu_ready", alu_ready, 32'd1);
      idle();
      chk("t1_we", rf_we, 32'd1);
      chk("t1_wa", rf_wa, 32'd5);
      chk("t1_wd", rf_wd, 32'h1ABCD);
      idle();
      chk("t1_we_low", rf_we, 32'd0);

      // Contention: grants alternate starting with the load unit.
      cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1);
      cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 2);
      cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1);
      cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 2);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 2, 'h00022, 1'b1, 1, 'h00011, 1'b0, 0);
         if (k > 0) chk("t2_wa", rf_wa, (k % 2 == 1) ? 32'd1 : 32'd2);
         #1 chk("t2_ld_ready", ld_ready, (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      idle();
      chk("t2_wa_last", rf_wa, 32'd2);
      chk("t2_wd_last", rf_wd, 32'h00022);
      idle();
      chk("t2_busy", busy, 32'd0);
      chk("t2_err", sb_err, 32'd0);

      // Two outstanding writes to r3.
      cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 3);
      cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 3);
      cyc(1'b1, 3, 'h3, 1'b0, 0, 0, 1'b0, 0);
      cyc(1'b1, 3, 'h33, 1'b0, 0, 0, 1'b0, 0);
      idle();
      chk("t3_busy_hi", busy[3], 32'd1);
      chk("t3_we", rf_we, 32'd1);
      idle();
      chk("t3_busy_lo", busy[3], 32'd0);

      // Issue and retire on r4 in the same cycle.
      cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 4);
      cyc(1'b1, 4, 'h44, 1'b0, 0, 0, 1'b0, 0);
      cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 4);
      idle();
      chk("t4_busy", busy[4], 32'd1);
      chk("t4_err", sb_err, 32'd0);
      cyc(1'b1, 4, 'h45, 1'b0, 0, 0, 1'b0, 0);
      idle();
      idle();
      chk("t4_busy_lo", busy, 32'd0);

      // Overflow on r6, then underflow on r7 after a reset.
      for (int k = 0; k < 4; k++) cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 6);
      idle();
      chk("t5_ovf_err", sb_err, 32'd1);
      chk("t5_busy6", busy[6], 32'd1);
      do_reset();
      cyc(1'b1, 7, 'h77, 1'b0, 0, 0, 1'b0, 0);
      idle();
      idle();
      chk("t5_udf_err", sb_err, 32'd1);

      // Reset with a pending write and the pointer moved to the ALU.
      cyc(1'b1, 0, 'h22, 1'b1, 1, 'h11, 1'b1, 5);
      do_reset();
      cyc(1'b1, 2, 'h22, 1'b1, 1, 'h11, 1'b0, 0);
      #1;
      chk("t6_ld_ready", ld_ready, 32'd1);
      chk("t6_alu_ready", alu_ready, 32'd0);
      idle();
      idle();
      idle();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
